branch_hazard_ctrl: RTL and testbench
=====================================

BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be as follows, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- br_valid  in  1  EX stage holds a branch/jump.
- br_cond  in  1  condition result from the EX-stage condition checker.
- br_target  in  WORD_LEN  EX-stage branch target.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  4  EX destination register.
- id_rs1, id_rs2  in  4 each  ID source registers.
- imem_ready  in  1  instruction memory accepts the fetch address this cycle.
- pc_sel  out  1  1 = PC takes pc_target.
- pc_target  out  WORD_LEN  redirect address.
- stall_pc, stall_ifid  out  1 each  hold the PC / IF-ID register.
- flush_ifid, flush_idex  out  1 each  insert a bubble.
- taken_cnt, stall_cnt  out  16 each  performance counters.

Function
REQ-003 The FSM SHALL have states RUN, REDIRECT and LDSTALL.
REQ-004 Taken SHALL be br_valid & br_cond; load-use SHALL be ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-005 In RUN with taken, the block SHALL assert pc_sel=1, pc_target=br_target, flush_ifid=1 and flush_idex=1 in the same cycle (combinational), and SHALL register br_target into tgt_q.
REQ-006 In RUN with taken and imem_ready=0, the next state SHALL be REDIRECT; with imem_ready=1 it SHALL stay RUN.
REQ-007 In REDIRECT, the block SHALL drive pc_sel=1, pc_target=tgt_q, flush_ifid=1 and flush_idex=0 (EX already bubbled), and return to RUN in the cycle after imem_ready=1.
REQ-008 In REDIRECT, br_valid, br_cond and load-use SHALL be ignored, because their sources are flushed instructions.
REQ-009 In RUN with load-use and not taken, the block SHALL assert stall_pc=1, stall_ifid=1 and flush_idex=1 for exactly one cycle, and the next state SHALL be LDSTALL.
REQ-010 LDSTALL SHALL drive all control outputs to 0, SHALL re-evaluate taken for that cycle exactly as in RUN (REQ-005/006), and SHALL then return to RUN or move to REDIRECT. Load-use is not re-checked in LDSTALL (the load has moved to MEM).
REQ-011 Taken SHALL override load-use in the same cycle: no stall is asserted and stall_cnt does not increment.
REQ-012 With no event in RUN, all control outputs SHALL be 0 and pc_target SHALL equal tgt_q.
REQ-013 taken_cnt SHALL increment once per accepted taken event (RUN or LDSTALL entry cycle), not per REDIRECT cycle.
REQ-014 stall_cnt SHALL increment once per load-use stall cycle.
REQ-015 Both counters SHALL saturate at 16'hFFFF with no wrap.
REQ-016 stall_pc and pc_sel SHALL never be 1 in the same cycle.

Reset
REQ-017 While rst=1 at a rising edge, the block SHALL load state=RUN, tgt_q=0, taken_cnt=0 and stall_cnt=0.
REQ-018 During and immediately after reset, all control outputs SHALL be 0 and pc_target SHALL be 0.
REQ-019 Reset asserted in REDIRECT or LDSTALL SHALL abandon the operation with no residual flush or stall.

Structure
REQ-020 The state encoding (2-bit enum), REG_ADDR_LEN=4 and WORD_LEN SHALL reside in the shared defines/package used by the control unit.
REQ-021 Load-use comparison SHALL live in sub-module load_use_detector (combinational). The FSM, tgt_q and counters SHALL live in branch_hazard_ctrl.

Verification
REQ-022 Reset with br_valid=1 and br_cond=1 held -> all outputs 0 and counters 0 until the first cycle after rst drops.
REQ-023 RUN, taken with br_target=32'h40 and imem_ready=1 -> one cycle with pc_sel=1, pc_target=32'h40, both flushes=1; next cycle all 0; taken_cnt=1.
REQ-024 Taken with target 32'h80 and imem_ready low for 3 cycles -> cycle0 both flushes; cycles 1-3 pc_sel=1, pc_target=32'h80, flush_ifid=1 only; RUN after imem_ready=1; taken_cnt=1.
REQ-025 ex_mem_read=1, ex_rd=5, id_rs2=5 -> one cycle stall_pc=stall_ifid=flush_idex=1, then LDSTALL with outputs 0; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
REQ-026 Load-use and taken in the same cycle -> redirect only; stall_cnt unchanged.
REQ-027 Preload stall_cnt near 16'hFFFF and force 3 stalls -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared widths, FSM encoding and a saturating-increment helper for the
// branch/load-use hazard controller.
package branch_hazard_ctrl_pkg;

    localparam int WORD_LEN     = 32;
    localparam int REG_ADDR_LEN = 4;
    localparam int CNT_LEN      = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_LDSTALL  = 2'd2
    } state_t;

    function automatic logic [CNT_LEN-1:0] sat_inc(input logic [CNT_LEN-1:0] value,
                                                   input logic               en);
        return (en && (value != {CNT_LEN{1'b1}})) ? value + 1'b1 : value;
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: EX/ID operands in,
// PC redirect, stall/flush controls and performance counters out.
interface branch_hazard_ctrl_if;
    import branch_hazard_ctrl_pkg::*;

    logic                    br_valid;
    logic                    br_cond;
    logic [WORD_LEN-1:0]     br_target;
    logic                    ex_mem_read;
    logic [REG_ADDR_LEN-1:0] ex_rd;
    logic [REG_ADDR_LEN-1:0] id_rs1;
    logic [REG_ADDR_LEN-1:0] id_rs2;
    logic                    imem_ready;

    logic                    pc_sel;
    logic [WORD_LEN-1:0]     pc_target;
    logic                    stall_pc;
    logic                    stall_ifid;
    logic                    flush_ifid;
    logic                    flush_idex;
    logic [CNT_LEN-1:0]      taken_cnt;
    logic [CNT_LEN-1:0]      stall_cnt;

    modport master (
        output br_valid, br_cond, br_target, ex_mem_read, ex_rd, id_rs1, id_rs2, imem_ready,
        input  pc_sel, pc_target, stall_pc, stall_ifid, flush_ifid, flush_idex,
               taken_cnt, stall_cnt
    );

    modport slave (
        input  br_valid, br_cond, br_target, ex_mem_read, ex_rd, id_rs1, id_rs2, imem_ready,
        output pc_sel, pc_target, stall_pc, stall_ifid, flush_ifid, flush_idex,
               taken_cnt, stall_cnt
    );

endinterface

// File: rtl/branch_hazard_ctrl_load_use.sv
// Combinational load-use detector: EX load writing a register ID is about to read.
module load_use_detector
    import branch_hazard_ctrl_pkg::*;
(
    input  logic                    ex_mem_read,
    input  logic [REG_ADDR_LEN-1:0] ex_rd,
    input  logic [REG_ADDR_LEN-1:0] id_rs1,
    input  logic [REG_ADDR_LEN-1:0] id_rs2,
    output logic                    load_use
);

    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch redirect and load-use stall controller with saturating perf counters.
//
// state       | meaning
// ST_RUN      | normal flow; act on taken branch or load-use hazard
// ST_REDIRECT | holding redirect to tgt_q until imem accepts the fetch
// ST_LDSTALL  | cycle after a load-use stall; only taken is evaluated
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    branch_hazard_ctrl_if.slave bus
);

    state_t              state_q, state_d;
    logic [WORD_LEN-1:0] tgt_q, tgt_d;
    logic [CNT_LEN-1:0]  taken_cnt_q;
    logic [CNT_LEN-1:0]  stall_cnt_q;
    logic                taken, load_use;
    logic                taken_inc, stall_inc;
    logic                pc_sel, stall_pc, stall_ifid, flush_ifid, flush_idex;
    logic [WORD_LEN-1:0] pc_target;

    assign taken = bus.br_valid && bus.br_cond;

    load_use_detector u_load_use (
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .load_use    (load_use)
    );

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        taken_inc  = 1'b0;
        stall_inc  = 1'b0;
        pc_sel     = 1'b0;
        pc_target  = tgt_q;
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        case (state_q)
            ST_RUN, ST_LDSTALL: begin
                if (taken) begin
                    pc_sel     = 1'b1;
                    pc_target  = bus.br_target;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    tgt_d      = bus.br_target;
                    taken_inc  = 1'b1;
                    state_d    = bus.imem_ready ? ST_RUN : ST_REDIRECT;
                end else if ((state_q == ST_RUN) && load_use) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                    stall_inc  = 1'b1;
                    state_d    = ST_LDSTALL;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                // EX was already bubbled on entry; branch and hazard inputs here are stale.
                pc_sel     = 1'b1;
                flush_ifid = 1'b1;
                state_d    = bus.imem_ready ? ST_RUN : ST_REDIRECT;
            end
            default: state_d = ST_RUN;
        endcase
        // Reset masks the combinational outputs so nothing leaks before the first edge.
        if (rst) begin
            pc_sel     = 1'b0;
            pc_target  = '0;
            stall_pc   = 1'b0;
            stall_ifid = 1'b0;
            flush_ifid = 1'b0;
            flush_idex = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            tgt_q       <= '0;
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            taken_cnt_q <= sat_inc(taken_cnt_q, taken_inc);
            stall_cnt_q <= sat_inc(stall_cnt_q, stall_inc);
        end
    end

    assign bus.pc_sel     = pc_sel;
    assign bus.pc_target  = pc_target;
    assign bus.stall_pc   = stall_pc;
    assign bus.stall_ifid = stall_ifid;
    assign bus.flush_ifid = flush_ifid;
    assign bus.flush_idex = flush_idex;
    assign bus.taken_cnt  = taken_cnt_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_branch_hazard_ctrl;
    import branch_hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_hazard_ctrl_if bus ();

    branch_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Model: pending redirect flag, "previous cycle was a stall" flag, saved target, counts.
    bit          m_redir;
    bit          m_shadow;
    logic [31:0] m_tgt;
    int          m_taken;
    int          m_stall;

    logic [68:0] exp_v, obs_v;

    task automatic model_reset();
        m_redir  = 0;
        m_shadow = 0;
        m_tgt    = '0;
        m_taken  = 0;
        m_stall  = 0;
    endtask

    task automatic set_idle();
        bus.br_valid    = 1'b0;
        bus.br_cond     = 1'b0;
        bus.br_target   = '0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rd       = '0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.imem_ready  = 1'b1;
    endtask

    function automatic bit m_is_taken();
        return bus.br_valid && bus.br_cond;
    endfunction

    function automatic bit m_is_lu();
        return bus.ex_mem_read && (bus.ex_rd != 0) &&
               ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
    endfunction

    // Waits to mid-cycle and builds expected/observed vectors for this cycle.
    task automatic sample();
        logic [4:0]  c;
        logic [31:0] t;
        @(negedge clk);
        if (rst)                         begin c = 5'b00000; t = '0;            end
        else if (m_redir)                begin c = 5'b10010; t = m_tgt;         end
        else if (m_is_taken())           begin c = 5'b10011; t = bus.br_target; end
        else if (!m_shadow && m_is_lu()) begin c = 5'b01101; t = m_tgt;         end
        else                             begin c = 5'b00000; t = m_tgt;         end
        exp_v = {c, t, m_taken[15:0], m_stall[15:0]};
        obs_v = {bus.pc_sel, bus.stall_pc, bus.stall_ifid, bus.flush_ifid, bus.flush_idex,
                 bus.pc_target, bus.taken_cnt, bus.stall_cnt};
        vectors++;
    endtask

    task automatic advance();
        if (rst) begin
            model_reset();
        end else if (m_redir) begin
            m_redir  = !bus.imem_ready;
            m_shadow = 0;
        end else if (m_is_taken()) begin
            if (m_taken < 65535) m_taken++;
            m_tgt    = bus.br_target;
            m_redir  = !bus.imem_ready;
            m_shadow = 0;
        end else if (!m_shadow && m_is_lu()) begin
            if (m_stall < 65535) m_stall++;
            m_shadow = 1;
        end else begin
            m_shadow = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        bus.br_valid  = 1'b1;
        bus.br_cond   = 1'b1;
        bus.br_target = 32'hDEAD_BEEC;
        @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            sample();
            if (obs_v !== exp_v || obs_v !== 69'd0) begin
                errors++;
                $display("FAIL reset cyc%0d: got %h want %h", i, obs_v, 69'd0);
            end
            advance();
        end
        rst = 1'b0;
        set_idle();
        sample();
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs_v, exp_v);
        end
        advance();
    endtask

    task automatic test_taken_ready();
        bus.br_valid = 1'b1; bus.br_cond = 1'b1; bus.br_target = 32'h40; bus.imem_ready = 1'b1;
        sample();
        if (obs_v !== exp_v || bus.pc_target !== 32'h40 || bus.pc_sel !== 1'b1) begin
            errors++;
            $display("FAIL taken_ready: got %h want %h", obs_v, exp_v);
        end
        advance();
        set_idle();
        sample();
        if (obs_v !== exp_v || bus.taken_cnt !== 16'd1) begin
            errors++;
            $display("FAIL taken_ready_after: got %h want %h", obs_v, exp_v);
        end
        advance();
    endtask

    task automatic test_redirect_wait();
        for (int i = 0; i < 5; i++) begin
            set_idle();
            if (i == 0) begin
                bus.br_valid = 1'b1; bus.br_cond = 1'b1; bus.br_target = 32'h80;
            end
            // Stale branch/hazard inputs during REDIRECT must be ignored.
            if (i == 1) begin
                bus.br_valid = 1'b1; bus.br_cond = 1'b1; bus.br_target = 32'h1234;
                bus.ex_mem_read = 1'b1; bus.ex_rd = 4'd3; bus.id_rs1 = 4'd3;
            end
            bus.imem_ready = (i >= 3);
            sample();
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL redirect_wait cyc%0d: got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
        if (bus.taken_cnt !== 16'd2) begin
            errors++;
            $display("FAIL redirect_taken_cnt: got %0d want %0d", bus.taken_cnt, 2);
        end
        vectors++;
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 6; i++) begin
            set_idle();
            bus.ex_mem_read = 1'b1;
            bus.id_rs2      = (i < 3) ? 4'd5 : 4'd0;
            bus.ex_rd       = (i < 3) ? 4'd5 : 4'd0;
            if (i == 2) bus.ex_mem_read = 1'b0;
            sample();
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL load_use cyc%0d: got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_taken_overrides();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            if (i == 0) begin
                bus.ex_mem_read = 1'b1; bus.ex_rd = 4'd7; bus.id_rs1 = 4'd7;
                bus.br_valid = 1'b1; bus.br_cond = 1'b1; bus.br_target = 32'hC0;
            end
            sample();
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL taken_overrides cyc%0d: got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_ldstall_taken();
        for (int i = 0; i < 5; i++) begin
            set_idle();
            bus.ex_mem_read = (i < 2);
            bus.ex_rd = 4'd9; bus.id_rs1 = 4'd9;
            if (i == 1) begin
                bus.br_valid = 1'b1; bus.br_cond = 1'b1; bus.br_target = 32'h100;
                bus.imem_ready = 1'b0;
            end
            sample();
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL ldstall_taken cyc%0d: got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            rst = (i == 1);
            if (i == 0) begin
                bus.br_valid = 1'b1; bus.br_cond = 1'b1; bus.br_target = 32'h200;
                bus.imem_ready = 1'b0;
            end
            if (i == 1) bus.imem_ready = 1'b0;
            sample();
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_mid cyc%0d: got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        set_idle();
        force dut.stall_cnt_q = 16'hFFFD;
        #1;
        release dut.stall_cnt_q;
        m_stall = 65533;
        for (int i = 0; i < 7; i++) begin
            set_idle();
            bus.ex_mem_read = (i < 6);
            bus.ex_rd = 4'd2; bus.id_rs2 = 4'd2;
            sample();
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL saturation cyc%0d: got %h want %h", i, obs_v, exp_v);
            end
            advance();
        end
        if (bus.stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation_final: got %h want %h", bus.stall_cnt, 16'hFFFF);
        end
        vectors++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 49) == 0);
            bus.br_valid    = ($urandom_range(0, 3) == 0);
            bus.br_cond     = $urandom_range(0, 1);
            bus.br_target   = $urandom;
            bus.ex_mem_read = ($urandom_range(0, 2) == 0);
            bus.ex_rd       = 4'($urandom_range(0, 3));
            bus.id_rs1      = 4'($urandom_range(0, 3));
            bus.id_rs2      = 4'($urandom_range(0, 3));
            bus.imem_ready  = ($urandom_range(0, 2) != 0);
            sample();
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL random cyc%0d: got %h want %h", i, obs_v, exp_v);
            end
            if (bus.pc_sel === 1'b1 && bus.stall_pc === 1'b1) begin
                errors++;
                $display("FAIL pc_sel_stall_excl cyc%0d: got both 1 want not both", i);
            end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_taken_ready();
        test_redirect_wait();
        test_load_use();
        test_taken_overrides();
        test_ldstall_taken();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
